spi_reg_bank: RTL
=================

# spi_reg_bank

Parametrised SPI slave register bank for the board control FPGA: a single SPI chip-select addresses up to NREG read/write registers of NBIT bits each, replacing one-register-per-address write-only and read-only slaves. The block oversamples sclk/mosi/cs on the system clock, decodes a 7-bit address with a read/write flag, then either writes NBIT bits into the selected register or shifts the selected input port out on miso. Sits between the board SPI pins and the control/status fabric.

## Interface
- NBIT, 8: data word width per register (2..32).
- NREG, 4: number of registers (1..16); BASE_ADR+NREG ≤ 128.
- BASE_ADR, 1: 7-bit address of register 0.
- RST_VAL, all ones (NBIT bits): reset value of every write register.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- sclk  in  1  SPI clock, asynchronous, idle low (mode 0).
- mosi  in  1  SPI data in, MSB first.
- cs  in  1  SPI chip select, active low, asynchronous.
- miso  out  1  SPI data out; 1 when not driving read data.
- out  out  NREG*NBIT  write registers, register k at [k*NBIT +: NBIT].
- inport  in  NREG*NBIT  read-back values, same packing.
- wr_stb  out  NREG  one-clk pulse on bit k when register k is written.
- rd_stb  out  NREG  one-clk pulse on bit k when inport k is snapshotted.

## Operation
- sclk, cs, mosi each pass a 2-FF synchronizer plus one history FF; sclk rise = history 01, sclk fall = 10; cs fall/rise likewise. mosi sampled from its synchronized stage on sclk rise.
- Frame: cs fall, address byte {r_w, adr[6:0]} MSB first, then data words. r_w=1 write, r_w=0 read.
- States: IDLE, ADDR, WDATA, RDATA, IGNORE.
  - IDLE: on cs fall -> ADDR, bit counter 0.
  - ADDR: shift mosi on each sclk rise; on 8th bit compute idx = adr - BASE_ADR (7-bit); idx < NREG -> WDATA (r_w=1) or RDATA (r_w=0), else IGNORE.
  - WDATA: shift NBIT bits; on NBIT-th rise write out[idx], pulse wr_stb[idx].
  - RDATA: on entry snapshot inport[idx] into shift register, pulse rd_stb[idx]; miso = shift MSB; shift left on each sclk fall; word complete after NBIT rises.
  - After a complete data word: see Configuration (burst vs single).
  - IGNORE: miso=1, nothing written, until cs rise.
  - Any state: cs rise -> IDLE, counter cleared, partial word discarded.
- miso = 1 in IDLE, ADDR, IGNORE; shift MSB in RDATA.

## Timing
- Reset values: out = RST_VAL in every register, wr_stb=0, rd_stb=0, miso=1, state IDLE. Reset mid-frame: IDLE immediately; frame still in progress is ignored until next cs fall.
- sclk high and low time each ≥ 4 clk periods; cs setup to first sclk rise ≥ 4 clk.
- Edge detect latency: 3 clk from pin transition.
- Write: out[idx] and wr_stb[idx] update 1 clk after NBIT-th detected sclk rise.
- Read: snapshot and rd_stb 1 clk after 8th address rise detection; first data bit on miso before next sclk fall; master samples on sclk rise.
- cs rise and sclk rise detected same clk: cs rise wins, word discarded, no write.
- wr_stb/rd_stb never more than one bit high at a time.

## Configuration
- SPI_REG_BANK_BURST_EN defined: after each complete data word idx increments and the same direction continues (write next register / snapshot next inport); after idx = NREG-1 -> IGNORE (no wrap).
- Undefined: after first complete data word -> IGNORE until cs rise; one register per frame.

## Test plan
- Reset: rst 1 clk -> out all 8'hFF per register, miso=1, strobes 0.
- Write: frame 8'h82, 8'hA5 (reg 1) -> out[15:8]=8'hA5, wr_stb=4'b0010 one clk, other registers unchanged.
- Read: inport[31:24]=8'h3C, frame 8'h04 + 8 clocks -> miso shifts 0,0,1,1,1,1,0,0, rd_stb=4'b1000.
- Out of range: frame 8'h85, 8'h12 -> no write, no strobe, miso stays 1.
- Abort: write 8'h81 then 5 data bits, cs rise -> out[7:0] stays 8'hFF, no wr_stb.
- Burst (macro on): 8'h83, 8'h11, 8'h22, 8'h33 -> reg2=8'h11, reg3=8'h22, third word ignored; macro off -> only reg2=8'h11.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI slave register bank: NREG write registers and NREG read-back ports behind one chip select.
// Define SPI_REG_BANK_BURST_EN to auto-increment the register index across data words in one frame.
module spi_reg_bank #(
  parameter int              NBIT     = 8,
  parameter int              NREG     = 4,
  parameter int              BASE_ADR = 1,
  parameter logic [NBIT-1:0] RST_VAL  = '1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs,
  output logic                 miso,
  output logic [NREG*NBIT-1:0] out,
  input  logic [NREG*NBIT-1:0] inport,
  output logic [NREG-1:0]      wr_stb,
  output logic [NREG-1:0]      rd_stb
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SW = (NBIT > 8) ? NBIT - 1 : 7;
`ifdef SPI_REG_BANK_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, IGNORE} state_t;

  state_t                      state, state_nxt;
  logic [2:0]                  sclk_q, cs_q;
  logic [1:0]                  mosi_q;
  logic                        sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_b;
  logic [4:0]                  bit_cnt;
  logic [SW-1:0]               sh;
  logic [NBIT-1:0]             rd_sh;
  logic [IW-1:0]               idx;
  logic [NREG-1:0][NBIT-1:0]   out_q, in_arr;
  logic [6:0]                  adr_idx;
  logic                        in_range, last_reg, addr_done, word_done;

  assign out    = out_q;
  assign in_arr = inport;
  assign miso   = (state == RDATA) ? rd_sh[NBIT-1] : 1'b1;

  // Synchronizers are deliberately not reset: they keep tracking the pins so
  // a reset in mid-frame cannot fabricate a cs edge.
  always_ff @(posedge clk) begin
    sclk_q <= {sclk_q[1:0], sclk};
    cs_q   <= {cs_q[1:0], cs};
    mosi_q <= {mosi_q[0], mosi};
  end

  assign sclk_rise = (sclk_q[2:1] == 2'b01);
  assign sclk_fall = (sclk_q[2:1] == 2'b10);
  assign cs_rise   = (cs_q[2:1] == 2'b01);
  assign cs_fall   = (cs_q[2:1] == 2'b10);
  assign mosi_b    = mosi_q[1];

  always_comb begin
    state_nxt = state;
    addr_done = 1'b0;
    word_done = 1'b0;
    adr_idx   = {sh[5:0], mosi_b} - 7'(BASE_ADR);
    in_range  = (adr_idx < 7'(NREG));
    last_reg  = (idx == IW'(NREG - 1));
    if (cs_rise) state_nxt = IDLE;
    else begin
      case (state)
        IDLE: if (cs_fall) state_nxt = ADDR;
        ADDR: if (sclk_rise && bit_cnt == 5'd7) begin
          addr_done = 1'b1;
          state_nxt = !in_range ? IGNORE : (sh[6] ? WDATA : RDATA);
        end
        WDATA, RDATA: if (sclk_rise && bit_cnt == 5'(NBIT - 1)) begin
          word_done = 1'b1;
          if (!BURST || last_reg) state_nxt = IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sh      <= '0;
      rd_sh   <= '1;
      idx     <= '0;
      out_q   <= {NREG{RST_VAL}};
      wr_stb  <= '0;
      rd_stb  <= '0;
    end else begin
      state  <= state_nxt;
      wr_stb <= '0;
      rd_stb <= '0;
      if (sclk_rise) sh <= {sh[SW-2:0], mosi_b};
      if (cs_rise || state == IDLE || addr_done || word_done) bit_cnt <= '0;
      else if (sclk_rise) bit_cnt <= bit_cnt + 5'd1;
      // The fall closing the last address/data bit must not consume the fresh MSB.
      if (state == RDATA && sclk_fall && bit_cnt != '0) rd_sh <= rd_sh << 1;
      if (addr_done) begin
        idx <= adr_idx[IW-1:0];
        if (in_range && !sh[6]) begin
          rd_sh                  <= in_arr[adr_idx[IW-1:0]];
          rd_stb[adr_idx[IW-1:0]] <= 1'b1;
        end
      end
      if (word_done) begin
        if (state == WDATA) begin
          out_q[idx]  <= {sh[NBIT-2:0], mosi_b};
          wr_stb[idx] <= 1'b1;
        end
        if (BURST && !last_reg) begin
          idx <= idx + 1'b1;
          if (state == RDATA) begin
            rd_sh               <= in_arr[idx + 1'b1];
            rd_stb[idx + 1'b1]  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
